// File: rtl/track_frame_reader.sv
// Latches a 52x52 track bitmap and streams it as a 28x28 frame (2x2 OR-pooled,
// 1-pixel zero border), one pixel per valid/ready handshake, row-major.
module track_frame_reader #(
  parameter int unsigned BLKSIZE = 52,
  parameter int unsigned OUTSIZE = 28
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       track_valid,
  input  logic [BLKSIZE*BLKSIZE-1:0] track,
  input  logic [3:0]                 block_x,
  input  logic [3:0]                 block_y,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic                       pix_data,
  output logic [4:0]                 pix_row,
  output logic [4:0]                 pix_col,
  output logic                       pix_last,
  output logic [3:0]                 frame_block_x,
  output logic [3:0]                 frame_block_y,
  output logic                       busy,
  output logic                       done,
  output logic                       dropped
);

  localparam int unsigned TW   = BLKSIZE * BLKSIZE;
  localparam logic [4:0]  EDGE = 5'(OUTSIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FIN} state_t;

  state_t          r_state;
  logic [TW-1:0]   r_shadow;
  logic [4:0]      r_row;
  logic [4:0]      r_col;
  logic            r_valid;
  logic            r_busy;
  logic            r_done;
  logic [3:0]      r_bx;
  logic [3:0]      r_by;

  logic            w_last;
  logic            w_hs;
  logic            w_interior;
  logic [11:0]     w_ry;
  logic [11:0]     w_cx;
  logic [11:0]     w_base;
  logic            w_pix;

  assign w_last = (r_row == EDGE) && (r_col == EDGE);
  assign w_hs   = r_valid && pix_ready;

  // Pooled pixel: OR of the 2x2 source block under the current interior position
  always_comb begin
    w_interior = (r_row != 5'd0) && (r_row != EDGE) && (r_col != 5'd0) && (r_col != EDGE);
    w_ry       = 12'(r_row) - 12'd1;
    w_cx       = 12'(r_col) - 12'd1;
    w_base     = 12'd0;
    w_pix      = 1'b0;
    if (w_interior) begin
      w_base = w_ry * 12'(2 * BLKSIZE) + w_cx * 12'd2;
      w_pix  = r_shadow[w_base]
             | r_shadow[w_base + 12'd1]
             | r_shadow[w_base + 12'(BLKSIZE)]
             | r_shadow[w_base + 12'(BLKSIZE + 1)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_row    <= 5'd0;
      r_col    <= 5'd0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bx     <= 4'd0;
      r_by     <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (track_valid) begin
            r_shadow <= track;
            r_bx     <= block_x;
            r_by     <= block_y;
            r_row    <= 5'd0;
            r_col    <= 5'd0;
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_hs) begin
            if (w_last) begin
              r_row   <= 5'd0;
              r_col   <= 5'd0;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else if (r_col == EDGE) begin
              r_col <= 5'd0;
              r_row <= r_row + 5'd1;
            end else begin
              r_col <= r_col + 5'd1;
            end
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign pix_valid     = r_valid;
  assign pix_data      = w_pix;
  assign pix_row       = r_row;
  assign pix_col       = r_col;
  assign pix_last      = w_last;
  assign frame_block_x = r_bx;
  assign frame_block_y = r_by;
  assign busy          = r_busy;
  assign done          = r_done;
  // A track offered while a frame is still owned is lost in that same cycle
  assign dropped       = track_valid && (r_state != S_IDLE);

endmodule

// File: tb/tb_track_frame_reader.sv
// Self-checking bench for track_frame_reader: frame-level model plus directed literals.
module tb_track_frame_reader;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          track_valid = 1'b0;
  logic [2703:0] track = '0;
  logic [3:0]    block_x = 4'd0;
  logic [3:0]    block_y = 4'd0;
  logic          pix_ready = 1'b0;
  logic          pix_valid, pix_data, pix_last, busy, done, dropped;
  logic [4:0]    pix_row, pix_col;
  logic [3:0]    frame_block_x, frame_block_y;

  track_frame_reader dut (
    .clk(clk), .rst(rst), .track_valid(track_valid), .track(track),
    .block_x(block_x), .block_y(block_y), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_data(pix_data), .pix_row(pix_row),
    .pix_col(pix_col), .pix_last(pix_last), .frame_block_x(frame_block_x),
    .frame_block_y(frame_block_y), .busy(busy), .done(done), .dropped(dropped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: describes the cycle that follows the most recent negedge
  bit m_active, m_fin;
  int m_k, m_bx, m_by;
  bit m_frame[784];
  int cyc = 0;
  int beats, ones, one_pos, done_cnt, drop_cnt, t_acc, t_done;
  bit check_en = 1'b0;
  int ready_mode = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Pool the 52x52 bitmap into 26x26, then place it inside a zero border
  function automatic void build_frame(input logic [2703:0] bm);
    bit p[26][26];
    for (int y = 0; y < 26; y++)
      for (int x = 0; x < 26; x++) p[y][x] = 1'b0;
    for (int y = 0; y < 52; y++)
      for (int x = 0; x < 52; x++)
        if (bm[y*52 + x]) p[y/2][x/2] = 1'b1;
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        m_frame[r*28 + c] = (r >= 1 && r <= 26 && c >= 1 && c <= 26) ? p[r-1][c-1] : 1'b0;
  endfunction

  function automatic int model_ones();
    int n = 0;
    for (int i = 0; i < 784; i++) n += int'(m_frame[i]);
    return n;
  endfunction

  function automatic logic [2703:0] rand_bm(input int dens);
    logic [2703:0] bm;
    for (int i = 0; i < 2704; i++) bm[i] = ($urandom_range(0, 99) < dens);
    return bm;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    pix_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare process: check this cycle, then advance the model
  always @(negedge clk) begin
    if (check_en) begin
      if (m_active) begin
        chk("valid", 32'(pix_valid), 1);
        chk("busy", 32'(busy), 1);
        chk("done_in_stream", 32'(done), 0);
        chk("row", 32'(pix_row), 32'(m_k / 28));
        chk("col", 32'(pix_col), 32'(m_k % 28));
        chk("data", 32'(pix_data), 32'(m_frame[m_k]));
        chk("last", 32'(pix_last), 32'(m_k == 783));
      end else if (m_fin) begin
        chk("done", 32'(done), 1);
        chk("valid_fin", 32'(pix_valid), 0);
        chk("busy_fin", 32'(busy), 1);
      end else begin
        chk("valid_idle", 32'(pix_valid), 0);
        chk("done_idle", 32'(done), 0);
        chk("busy_idle", 32'(busy), 0);
        chk("row_idle", 32'(pix_row), 0);
        chk("col_idle", 32'(pix_col), 0);
        chk("last_idle", 32'(pix_last), 0);
        chk("data_idle", 32'(pix_data), 0);
      end
      chk("fbx", 32'(frame_block_x), 32'(m_bx));
      chk("fby", 32'(frame_block_y), 32'(m_by));
      chk("dropped", 32'(dropped), 32'(track_valid && (m_active || m_fin)));
      if (done === 1'b1) begin done_cnt++; t_done = cyc; end
      if (dropped === 1'b1) drop_cnt++;

      if (rst) begin
        m_active = 0; m_fin = 0; m_k = 0; m_bx = 0; m_by = 0;
      end else if (m_active) begin
        if (pix_ready) begin
          beats++;
          if (pix_data === 1'b1) begin ones++; one_pos = m_k; end
          m_k++;
          if (m_k == 784) begin m_active = 0; m_fin = 1; m_k = 0; end
        end
      end else if (m_fin) begin
        m_fin = 0;
      end else if (track_valid) begin
        build_frame(track);
        m_bx = int'(block_x); m_by = int'(block_y);
        m_active = 1; m_k = 0; t_acc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_stats();
    beats = 0; ones = 0; one_pos = -1;
  endtask

  task automatic send(input logic [2703:0] bm, input int bx, input int by);
    int b = 0;
    while ((m_active || m_fin) && b < 4000) begin step(); b++; end
    if (b >= 4000) chk("send_timeout", 1, 0);
    clear_stats();
    track = bm; block_x = 4'(bx); block_y = 4'(by);
    track_valid = 1'b1;
    step();
    track_valid = 1'b0;
  endtask

  task automatic wait_done();
    int b = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && b < 4000) begin step(); b++; end
    if (b >= 4000) chk("done_timeout", 1, 0);
    step();
  endtask

  task automatic wait_beats(input int n);
    int b = 0;
    while (beats < n && b < 4000) begin step(); b++; end
    if (b >= 4000) chk("beat_timeout", 1, 0);
  endtask

  task automatic run_single(input int bit_idx, input int exp_pos, input string nm);
    logic [2703:0] bm;
    bm = '0;
    bm[bit_idx] = 1'b1;
    send(bm, 1, 2);
    wait_done();
    chk({nm, "_beats"}, 32'(beats), 784);
    chk({nm, "_ones"}, 32'(ones), 1);
    chk({nm, "_pos"}, 32'(one_pos), 32'(exp_pos));
  endtask

  initial begin
    logic [2703:0] bm, bm2;
    int d0, ones_ref;
    done_cnt = 0; drop_cnt = 0;
    clear_stats();
    repeat (3) step();
    check_en = 1'b1;
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fbx", 32'(frame_block_x), 0);
    rst = 1'b0;
    step();

    // Single corner bit with block coordinates and latency
    bm = '0; bm[0] = 1'b1;
    send(bm, 3, 5);
    wait_done();
    chk("bit0_beats", 32'(beats), 784);
    chk("bit0_ones", 32'(ones), 1);
    chk("bit0_pos", 32'(one_pos), 29);
    chk("bit0_fbx", 32'(frame_block_x), 3);
    chk("bit0_fby", 32'(frame_block_y), 5);
    chk("bit0_latency", 32'(t_done - t_acc), 785);

    run_single(2703, 26*28 + 26, "bit2703");
    run_single(53, 29, "bit53");
    run_single(54, 30, "bit54");

    // All ones: full interior, empty border
    bm = '1;
    send(bm, 8, 8);
    wait_done();
    chk("ones_beats", 32'(beats), 784);
    chk("ones_count", 32'(ones), 676);

    // Same random bitmap under steady and toggling ready
    bm = rand_bm(20);
    send(bm, 4, 6);
    wait_done();
    ones_ref = ones;
    chk("rnd_model_ones", 32'(ones), 32'(model_ones()));
    ready_mode = 1;
    send(bm, 4, 6);
    wait_done();
    chk("bp_beats", 32'(beats), 784);
    chk("bp_ones", 32'(ones), 32'(ones_ref));

    // Track offered mid-stream is dropped
    drop_cnt = 0;
    bm = rand_bm(10);
    bm2 = ~bm;
    send(bm, 2, 7);
    wait_beats(100);
    track = bm2; block_x = 4'd6; block_y = 4'd1;
    track_valid = 1'b1;
    step();
    track_valid = 1'b0;
    wait_done();
    chk("drop_count", 32'(drop_cnt), 1);
    chk("drop_beats", 32'(beats), 784);
    chk("drop_fbx", 32'(frame_block_x), 2);

    // Reset mid-stream
    ready_mode = 0;
    bm = rand_bm(30);
    send(bm, 5, 5);
    wait_beats(400);
    d0 = done_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_valid", 32'(pix_valid), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_row", 32'(pix_row), 0);
    chk("rst_mid_col", 32'(pix_col), 0);
    repeat (5) step();
    chk("rst_mid_nodone", 32'(done_cnt), 32'(d0));
    bm = rand_bm(25);
    send(bm, 7, 3);
    wait_done();
    chk("post_rst_beats", 32'(beats), 784);
    chk("post_rst_ones", 32'(ones), 32'(model_ones()));

    // Random frames, varying density and ready behaviour
    for (int f = 0; f < 4; f++) begin
      ready_mode = f % 2;
      bm = rand_bm(5 + f * 15);
      send(bm, $urandom_range(0, 8), $urandom_range(0, 8));
      wait_done();
      chk("rnd_beats", 32'(beats), 784);
      chk("rnd_ones", 32'(ones), 32'(model_ones()));
    end

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
